// File: rtl/cache_stats_ctrl_if.sv
// Request/response and block-fetch bus of the statistics cache controller.
//   req_valid/req_ready/req_addr       : word-address read request handshake
//   resp_valid/resp_data/resp_hit      : one-cycle response strobe + held word/hit flag
//   mem_req/mem_block_addr             : block fetch request, held until mem_valid
//   mem_valid/mem_data                 : single-cycle fetched block, word 0 in LSBs
// slave modport = controller side, master modport = requester/memory side.
interface cache_stats_ctrl_if #(
  parameter int ADDR_W   = 15,
  parameter int OFFSET_W = 2,
  parameter int WORD_W   = 32
);
  localparam int BLK_W = WORD_W << OFFSET_W;

  logic                       req_valid;
  logic                       req_ready;
  logic [ADDR_W-1:0]          req_addr;
  logic                       resp_valid;
  logic [WORD_W-1:0]          resp_data;
  logic                       resp_hit;
  logic                       mem_req;
  logic [ADDR_W-OFFSET_W-1:0] mem_block_addr;
  logic                       mem_valid;
  logic [BLK_W-1:0]           mem_data;

  modport slave (
    input  req_valid, req_addr, mem_valid, mem_data,
    output req_ready, resp_valid, resp_data, resp_hit, mem_req, mem_block_addr
  );

  modport master (
    output req_valid, req_addr, mem_valid, mem_data,
    input  req_ready, resp_valid, resp_data, resp_hit, mem_req, mem_block_addr
  );
endinterface

// File: rtl/cache_stats_ctrl.sv
// Direct-mapped read-only cache controller with hit/access statistics.
// Requests are looked up in a local line store; misses fetch a whole block
// over the mem_* side. Every response bumps access_count (and hit_count on
// hits); once access_count reaches ACCESS_LIMIT the block parks in DONE
// until clear_stats_i.
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   bus              : request/response/fetch interface (slave side)
//   clear_stats_i    : zero counters and leave DONE (honoured in IDLE/DONE)
//   hit_count_o      : hits recorded (saturating)
//   access_count_o   : responses recorded (saturating)
//   done_o           : access limit reached
module cache_stats_ctrl #(
  parameter int ADDR_W       = 15,
  parameter int INDEX_W      = 10,
  parameter int OFFSET_W     = 2,
  parameter int WORD_W       = 32,
  parameter int ACCESS_LIMIT = 8192,
  parameter int CNT_W        = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  cache_stats_ctrl_if.slave    bus,
  input  logic                 clear_stats_i,
  output logic [CNT_W-1:0]     hit_count_o,
  output logic [CNT_W-1:0]     access_count_o,
  output logic                 done_o
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLK_W = WORD_W << OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(ACCESS_LIMIT);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, DONE} state_t;

  typedef struct packed {
    logic              hit;
    logic [WORD_W-1:0] data;
  } resp_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  resp_t                      pend_q, pend_d;   // word/hit waiting to be answered
  resp_t                      resp_q, resp_d;   // visible response, held between strobes
  logic                       resp_vld_q, resp_vld_d;
  logic                       mem_req_q, mem_req_d;
  logic [ADDR_W-OFFSET_W-1:0] mba_q, mba_d;
  logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]           acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]           acc_inc;
  logic                       done_q, done_d;
  logic                       req_ready;
  logic                       fill_we;

  logic [BLK_W-1:0]           data_q [LINES];
  logic [TAG_W-1:0]           tag_q  [LINES];
  logic [LINES-1:0]           valid_q;

  logic [OFFSET_W-1:0]        off;
  logic [INDEX_W-1:0]         idx;
  logic [TAG_W-1:0]           tag;
  logic                       lookup_hit;

  assign off = addr_q[OFFSET_W-1:0];
  assign idx = addr_q[OFFSET_W +: INDEX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign acc_inc = sat_inc(acc_cnt_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    resp_d     = resp_q;
    resp_vld_d = 1'b0;
    mem_req_d  = mem_req_q;
    mba_d      = mba_q;
    hit_cnt_d  = hit_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    done_d     = done_q;
    req_ready  = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (clear_stats_i) begin
          hit_cnt_d = '0;
          acc_cnt_d = '0;
          done_d    = 1'b0;
        end
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          pend_d.hit  = 1'b1;
          pend_d.data = data_q[idx][int'(off)*WORD_W +: WORD_W];
          state_d     = RESPOND;
        end else begin
          pend_d.hit = 1'b0;
          mem_req_d  = 1'b1;
          mba_d      = {tag, idx};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (bus.mem_valid) begin
          fill_we     = 1'b1;
          pend_d.data = bus.mem_data[int'(off)*WORD_W +: WORD_W];
          mem_req_d   = 1'b0;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        resp_vld_d = 1'b1;
        resp_d     = pend_q;
        acc_cnt_d  = acc_inc;
        if (pend_q.hit) hit_cnt_d = sat_inc(hit_cnt_q);
        if (acc_inc == LIMIT) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (clear_stats_i) begin
          hit_cnt_d = '0;
          acc_cnt_d = '0;
          done_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pend_q     <= '0;
      resp_q     <= '0;
      resp_vld_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mba_q      <= '0;
      hit_cnt_q  <= '0;
      acc_cnt_q  <= '0;
      done_q     <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      resp_q     <= resp_d;
      resp_vld_q <= resp_vld_d;
      mem_req_q  <= mem_req_d;
      mba_q      <= mba_d;
      hit_cnt_q  <= hit_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      done_q     <= done_d;
      if (fill_we) valid_q[idx] <= 1'b1;
    end
  end

  // Line payload and tags carry no reset; validity lives in valid_q.
  // Gate on rst_n_i so a mem_valid coinciding with reset leaves no trace.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && fill_we) begin
      data_q[idx] <= bus.mem_data;
      tag_q[idx]  <= tag;
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.resp_valid     = resp_vld_q;
  assign bus.resp_data      = resp_q.data;
  assign bus.resp_hit       = resp_q.hit;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_block_addr = mba_q;
  assign hit_count_o        = hit_cnt_q;
  assign access_count_o     = acc_cnt_q;
  assign done_o             = done_q;
endmodule

// File: tb/tb_cache_stats_ctrl.sv
// Directed bench for cache_stats_ctrl with ACCESS_LIMIT=4.
module tb_cache_stats_ctrl;
  localparam int ADDR_W = 15, INDEX_W = 10, OFFSET_W = 2, WORD_W = 32, CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_stats;
  logic [CNT_W-1:0] hit_count, access_count;
  logic done;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_stats_ctrl_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .WORD_W(WORD_W)) bus ();

  cache_stats_ctrl #(
    .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WORD_W(WORD_W),
    .ACCESS_LIMIT(4), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .clear_stats_i(clear_stats),
    .hit_count_o(hit_count), .access_count_o(access_count), .done_o(done)
  );

  localparam logic [127:0] BLK_A = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
  localparam logic [127:0] BLK_B = {32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};
  localparam logic [127:0] BLK_C = {32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001, 32'hC0C0_0000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] d, input logic h,
                          input int hc, input int ac);
    chk({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, "_data"},  64'(bus.resp_data), 64'(d));
    chk({tag, "_hit"},   64'(bus.resp_hit), 64'(h));
    chk({tag, "_hitcnt"}, 64'(hit_count), 64'(hc));
    chk({tag, "_acccnt"}, 64'(access_count), 64'(ac));
  endtask

  initial begin
    int seen;
    logic [12:0] mba_ref;
    rst_n = 1'b0;
    clear_stats = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    tick(2);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mba", 64'(bus.mem_block_addr), 64'd0);
    chk("rst_hitcnt", 64'(hit_count), 64'd0);
    chk("rst_acccnt", 64'(access_count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: cold miss on 0x0004, block returned after 3 cycles
    issue(15'h0004);
    chk("t1_ready_busy", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t1_mem_req", 64'(bus.mem_req), 64'd1);
    chk("t1_mba", 64'(bus.mem_block_addr), 64'h001);
    tick(2);
    chk("t1_mem_req_held", 64'(bus.mem_req), 64'd1);
    bus.mem_valid = 1'b1;
    bus.mem_data  = BLK_A;
    tick();
    bus.mem_valid = 1'b0;
    chk("t1_mem_req_drop", 64'(bus.mem_req), 64'd0);
    chk("t1_no_resp_yet", 64'(bus.resp_valid), 64'd0);
    tick();
    chk_resp("t1", 32'hA0A0_0000, 1'b0, 0, 1);
    tick();
    chk("t1_resp_1cyc", 64'(bus.resp_valid), 64'd0);
    chk("t1_data_hold", 64'(bus.resp_data), 64'hA0A0_0000);

    // 2: hit on same block, offset 1
    issue(15'h0005);
    tick();
    chk("t2_no_memreq", 64'(bus.mem_req), 64'd0);
    chk("t2_not_early", 64'(bus.resp_valid), 64'd0);
    tick();
    chk_resp("t2", 32'hA0A0_0001, 1'b1, 1, 2);
    tick();

    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr1_acc", 64'(access_count), 64'd0);
    chk("clr1_hit", 64'(hit_count), 64'd0);

    // 3: conflict eviction on index 1
    issue(15'h0004);
    tick(2);
    chk_resp("t3a", 32'hA0A0_0000, 1'b1, 1, 1);
    tick();
    issue(15'h1004);
    tick();
    chk("t3b_mem_req", 64'(bus.mem_req), 64'd1);
    chk("t3b_mba", 64'(bus.mem_block_addr), 64'h401);
    bus.mem_valid = 1'b1;
    bus.mem_data  = BLK_B;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    chk_resp("t3b", 32'hB0B0_0000, 1'b0, 1, 2);
    tick();
    issue(15'h0004);
    tick();
    chk("t3c_mem_req", 64'(bus.mem_req), 64'd1);
    chk("t3c_mba", 64'(bus.mem_block_addr), 64'h001);
    bus.mem_valid = 1'b1;
    bus.mem_data  = BLK_A;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    chk_resp("t3c", 32'hA0A0_0000, 1'b0, 1, 3);

    // 4: fourth response reaches the limit
    tick();
    issue(15'h0006);
    tick(2);
    chk_resp("t4", 32'hA0A0_0002, 1'b1, 2, 4);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 15'h0005;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.req_ready || bus.resp_valid || bus.mem_req) seen++;
    end
    bus.req_valid = 1'b0;
    chk("t4_no_accept", 64'(seen), 64'd0);
    chk("t4_acc_frozen", 64'(access_count), 64'd4);
    chk("t4_hit_frozen", 64'(hit_count), 64'd2);
    chk("t4_done_held", 64'(done), 64'd1);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t4_clr_acc", 64'(access_count), 64'd0);
    chk("t4_clr_hit", 64'(hit_count), 64'd0);
    chk("t4_clr_done", 64'(done), 64'd0);
    chk("t4_clr_ready", 64'(bus.req_ready), 64'd1);

    // 5: reset mid-refill, late mem_valid ignored, line stays invalid
    issue(15'h0008);
    tick();
    chk("t5_mba", 64'(bus.mem_block_addr), 64'h002);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("t5_rst_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_data  = BLK_C;
    tick();
    bus.mem_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid) seen++;
      tick();
    end
    chk("t5_no_resp", 64'(seen), 64'd0);
    chk("t5_acc", 64'(access_count), 64'd0);
    issue(15'h0008);
    tick();
    chk("t5_remiss", 64'(bus.mem_req), 64'd1);

    // 6: slow memory, 20 cycles in REFILL
    mba_ref = bus.mem_block_addr;
    chk("t6_mba", 64'(mba_ref), 64'h002);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.mem_req || bus.mem_block_addr !== mba_ref || bus.req_ready || bus.resp_valid) seen++;
    end
    chk("t6_held", 64'(seen), 64'd0);
    bus.mem_valid = 1'b1;
    bus.mem_data  = BLK_C;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    chk_resp("t6", 32'hC0C0_0000, 1'b0, 0, 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.resp_valid) seen++;
    end
    chk("t6_single_resp", 64'(seen), 64'd0);
    chk("t6_acc_final", 64'(access_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_stats_ctrl.md
Name: cache_stats_ctrl

Overview:
Parametrised direct-mapped cache controller with built-in hit/access statistics, used in place of the free-running array/cache/counter datapath. Requests arrive over a valid/ready handshake and are decoded into tag/index/word offset. Hits answer from the local line store. Misses issue a variable-latency block fetch to main memory. Hit and access counts are tracked up to a configurable access limit, after which the block stops accepting requests.

Parameters:
ADDR_W, 15, request word-address width
INDEX_W, 10, index bits (2^INDEX_W lines)
OFFSET_W, 2, word-offset bits (2^OFFSET_W words per block)
WORD_W, 32, data word width
ACCESS_LIMIT, 8192, number of responses before DONE
CNT_W, 32, statistics counter width
(derived) TAG_W = ADDR_W-INDEX_W-OFFSET_W; BLK_W = WORD_W<<OFFSET_W

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_addr  in  ADDR_W  word address {tag,index,offset}
resp_valid  out  1  one-cycle response strobe
resp_data  out  WORD_W  read word
resp_hit  out  1  response was a hit
mem_req  out  1  block fetch request, held until mem_valid
mem_block_addr  out  ADDR_W-OFFSET_W  {tag,index} of the fetched block
mem_valid  in  1  fetch data valid (single cycle)
mem_data  in  BLK_W  fetched block, word 0 in LSBs
clear_stats  in  1  zero counters and leave DONE
hit_count  out  CNT_W  hits recorded
access_count  out  CNT_W  responses recorded
done  out  1  access limit reached

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all line valid bits cleared; hit_count=0, access_count=0, done=0, resp_valid=0, resp_hit=0, resp_data=0, mem_req=0, mem_block_addr=0. Tag/data storage need not be cleared.
- States: IDLE, LOOKUP, REFILL, RESPOND, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_addr and go to LOOKUP. req_ready=0 in every other state.
- LOOKUP: hit = valid[index] && tag_store[index]==tag.
  - Hit: select word `offset` of the line and go to RESPOND.
  - Miss: register mem_req=1 and mem_block_addr={tag,index}, then go to REFILL.
- REFILL: mem_req stays 1 until the cycle mem_valid=1. On that edge:
  - write mem_data into line[index], tag_store[index]=tag, valid[index]=1;
  - capture word `offset` of mem_data as the response;
  - drop mem_req; go to RESPOND.
  - No timeout.
- RESPOND: resp_valid=1 for exactly one cycle. resp_data and resp_hit are registered and hold until the next response. On the same edge:
  - access_count++;
  - hit_count++ if hit;
  - if the new access_count==ACCESS_LIMIT, go to DONE and set done=1; else go to IDLE.
- Latency from accept edge to resp_valid:
  - hit: 2 cycles;
  - miss: 1 cycle after the mem_valid edge.
- DONE: no requests accepted; done=1 held.
- clear_stats: sampled only in IDLE and DONE. Zeroes both counters and done; DONE returns to IDLE. Ignored in LOOKUP/REFILL/RESPOND. Never touches valid bits.
- Counters saturate at 2^CNT_W-1. Never wrap.
- mem_valid outside REFILL is ignored. This includes a late mem_valid after a reset mid-refill.
- Reset in any state overrides everything, including clear_stats and mem_valid in the same cycle.
- A write to a line overwrites the previous tag (conflict eviction). There is no write path; the block is read-only.

Test Plan:
1. Reset, read 0x0004 → mem_req=1 with mem_block_addr=0x001; return block {W3,W2,W1,W0=0xA0A0_0000} after 3 cycles → resp_valid 1 cycle later, resp_data=0xA0A0_0000, resp_hit=0, access_count=1, hit_count=0.
2. Then read 0x0005 (same block, offset 1) → no mem_req, resp_valid 2 cycles after accept, resp_data=W1, resp_hit=1, hit_count=1, access_count=2.
3. Conflict: 0x0004 (hit), 0x1004 (index 1, tag 1 → miss, fetch 0x401), 0x0004 (miss again, fetch 0x001) → hit_count increments only for the first access.
4. ACCESS_LIMIT=4: after the 4th resp_valid, done=1 and req_ready=0; req_valid held 10 cycles → no accept, counters frozen. Pulse clear_stats → counters 0, done=0, req_ready=1 next cycle.
5. Assert rst_n=0 during REFILL, then mem_valid 2 cycles after reset releases → ignored, no resp_valid. Re-read the same address → miss (valid cleared).
6. Delay mem_valid by 20 cycles → mem_req held high and mem_block_addr stable throughout, req_ready=0, exactly one resp_valid follows.
